// File: rtl/b8_bitplane_feeder.sv
// Bit-plane feeder for the 16-lane bit-serial inner-product stage.
// Holds activations and streams weight bit-planes MSB-first, one per cycle.
module b8_bitplane_feeder #(
    parameter int N     = 16,
    parameter int ABITS = 8,
    parameter int WBITS = 8,
    parameter int CW    = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N*ABITS-1:0] act_i,
    input  logic [N*WBITS-1:0] wgt_i,
    output logic [N*ABITS-1:0] act_o,
    output logic [N-1:0]       wbit_o,
    output logic               plane_valid,
    output logic               plane_first,
    output logic               plane_last,
    output logic [CW-1:0]      plane_idx,
    output logic               done
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic [CW-1:0] IDX_MSB = CW'(WBITS - 1);

    state_t             state_q, state_d;
    logic [N*ABITS-1:0] act_q, act_d;
    logic [N*WBITS-1:0] w_q, w_d;
    logic [CW-1:0]      idx_q, idx_d;
    logic               done_q, done_d;
    logic               last;
    logic               accept;

    // Next-state logic: accept a job, or advance one bit-plane per cycle.
    always_comb begin
        state_d  = state_q;
        act_d    = act_q;
        w_d      = w_q;
        idx_d    = idx_q;
        last     = (state_q == SHIFT) && (idx_q == '0);
        in_ready = (state_q == IDLE) || last;
        accept   = in_valid && in_ready;
        done_d   = last;
        if (accept) begin
            state_d = SHIFT;
            act_d   = act_i;
            w_d     = wgt_i;
            idx_d   = IDX_MSB;
        end else if (state_q == SHIFT) begin
            for (int k = 0; k < N; k++) begin
                w_d[k*WBITS +: WBITS] = w_q[k*WBITS +: WBITS] << 1;
            end
            if (last) begin
                state_d = IDLE;
            end else begin
                idx_d = idx_q - 1'b1;
            end
        end
    end

    // Plane outputs: the MSB of each lane's shift register is the live bit.
    always_comb begin
        wbit_o      = '0;
        plane_valid = (state_q == SHIFT);
        plane_first = (state_q == SHIFT) && (idx_q == IDX_MSB);
        plane_last  = last;
        plane_idx   = idx_q;
        act_o       = act_q;
        done        = done_q;
        if (state_q == SHIFT) begin
            for (int k = 0; k < N; k++) begin
                wbit_o[k] = w_q[k*WBITS + WBITS - 1];
            end
        end
    end

    // State and datapath registers; reset aborts any job in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            act_q   <= '0;
            w_q     <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            act_q   <= act_d;
            w_q     <= w_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
        end
    end

endmodule
